// File: rtl/dmem_lsu_pkg.sv
// Shared types and combinational helpers for the data-memory load/store unit.
// Helpers use fixed maximum widths; callers truncate results to their real data width.
package dmem_lsu_pkg;

  localparam int unsigned LSU_MAX_DW  = 256;
  localparam int unsigned LSU_MAX_COL = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } lsu_state_e;

  typedef logic [LSU_MAX_DW-1:0]  lsu_wide_t;
  typedef logic [LSU_MAX_COL-1:0] lsu_be_t;

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [31:0] lane);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = lane[0];
      SZ_WORD: res = (lane != 32'd0);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic lsu_be_t lsu_byte_en(input lsu_size_e size, input logic [31:0] lane,
                                          input int unsigned nb_col);
    lsu_be_t one;
    lsu_be_t res;
    one = LSU_MAX_COL'(1);
    case (size)
      SZ_BYTE: res = one << lane;
      SZ_HALF: res = LSU_MAX_COL'(3) << lane;
      SZ_WORD: res = (one << nb_col) - one;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Narrow stores replicate their data across every column slot, so the byte
  // enables alone select which lane is actually written.
  function automatic lsu_wide_t lsu_store_data(input lsu_size_e size, input lsu_wide_t wdata,
                                               input int unsigned cw, input int unsigned nb_col);
    lsu_wide_t one;
    lsu_wide_t col_mask;
    lsu_wide_t half_mask;
    lsu_wide_t res;
    one       = LSU_MAX_DW'(1);
    col_mask  = (one << cw) - one;
    half_mask = (one << (2 * cw)) - one;
    res       = '0;
    case (size)
      SZ_BYTE: begin
        for (int unsigned i = 0; i < LSU_MAX_COL; i++)
          if (i < nb_col) res |= (wdata & col_mask) << (i * cw);
      end
      SZ_HALF: begin
        for (int unsigned i = 0; i < LSU_MAX_COL / 2; i++)
          if (i < nb_col / 2) res |= (wdata & half_mask) << (i * 2 * cw);
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  function automatic lsu_wide_t lsu_format_load(input lsu_wide_t word, input lsu_size_e size,
                                                input logic [31:0] lane, input logic uns,
                                                input int unsigned cw);
    lsu_wide_t   one;
    lsu_wide_t   shifted;
    lsu_wide_t   mask;
    lsu_wide_t   res;
    int unsigned fw;
    logic        sign;
    one     = LSU_MAX_DW'(1);
    fw      = (size == SZ_BYTE) ? cw : 2 * cw;
    shifted = word >> (lane * cw);
    mask    = (one << fw) - one;
    sign    = |(shifted & (one << (fw - 1)));
    if (size == SZ_WORD || size == SZ_ILL)
      res = word;
    else
      res = (shifted & mask) | ((sign && !uns) ? ~mask : '0);
    return res;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_bram.sv
// Single-port byte-enable block RAM with a READ_LAT-deep read-data pipeline.
module bram_be #(
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_en,
  input  logic [NB_COL-1:0]             i_we,
  input  logic [$clog2(RAM_DEPTH)-1:0]  i_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   i_wdata,
  output logic [NB_COL*COL_WIDTH-1:0]   o_rdata
);

  localparam int unsigned DATA_W = NB_COL * COL_WIDTH;

  logic [DATA_W-1:0] r_mem  [RAM_DEPTH];
  logic [DATA_W-1:0] r_pipe [READ_LAT];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int unsigned c = 0; c < NB_COL; c++)
        if (i_we[c]) r_mem[i_addr][c*COL_WIDTH +: COL_WIDTH] <= i_wdata[c*COL_WIDTH +: COL_WIDTH];
      r_pipe[0] <= r_mem[i_addr];
    end
    for (int unsigned s = 1; s < READ_LAT; s++)
      r_pipe[s] <= r_pipe[s-1];
  end

  assign o_rdata = r_pipe[READ_LAT-1];

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller: valid/ready request, byte-lane stores, sign/zero-extended
// loads with configurable BRAM latency, and misalignment/illegal-size errors.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter  int unsigned NB_COL    = 4,
  parameter  int unsigned COL_WIDTH = 8,
  parameter  int unsigned RAM_DEPTH = 1024,
  parameter  int unsigned READ_LAT  = 1,
  localparam int unsigned DATA_W    = NB_COL * COL_WIDTH,
  localparam int unsigned LANE_W    = $clog2(NB_COL),
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH),
  localparam int unsigned ADDR_W    = RAM_AW + LANE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [LANE_W-1:0] r_lane;
  lsu_size_e         r_size;
  logic              r_uns;

  logic [LANE_W-1:0] w_lane;
  logic [RAM_AW-1:0] w_word;
  lsu_size_e         w_size;
  logic              w_accept;
  logic              w_err;
  logic              w_mem_en;
  logic              w_done;
  logic [NB_COL-1:0] w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_bram_rdata;
  logic [DATA_W-1:0] w_fmt;

  assign w_lane    = req_addr[LANE_W-1:0];
  assign w_word    = req_addr[ADDR_W-1:LANE_W];
  assign w_size    = lsu_size_e'(req_size);
  assign req_ready = (r_state == IDLE) && !RST;
  assign w_accept  = req_valid && req_ready;
  assign w_err     = lsu_misaligned(w_size, 32'(w_lane));
  assign w_mem_en  = w_accept && !w_err;
  assign w_be      = (w_mem_en && req_we) ? NB_COL'(lsu_byte_en(w_size, 32'(w_lane), NB_COL)) : '0;
  assign w_wdata   = DATA_W'(lsu_store_data(w_size, LSU_MAX_DW'(req_wdata), COL_WIDTH, NB_COL));
  // Read data reaches the pipeline output in the last RD_WAIT cycle (counter at 1).
  assign w_done    = (r_state == RD_WAIT) && (r_cnt == CNT_W'(1));
  assign w_fmt     = DATA_W'(lsu_format_load(LSU_MAX_DW'(w_bram_rdata), r_size, 32'(r_lane),
                                             r_uns, COL_WIDTH));

  bram_be #(
    .NB_COL   (NB_COL),
    .COL_WIDTH(COL_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .READ_LAT (READ_LAT)
  ) u_bram (
    .i_clk  (CLK),
    .i_en   (w_mem_en),
    .i_we   (w_be),
    .i_addr (w_word),
    .i_wdata(w_wdata),
    .o_rdata(w_bram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_mem_en && !req_we) w_state_nxt = RD_WAIT;
      RD_WAIT: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      r_cnt     <= '0;
      r_lane    <= '0;
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (w_accept) begin
        if (w_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else if (req_we) begin
          rsp_valid <= 1'b1;
        end else begin
          r_lane <= w_lane;
          r_size <= w_size;
          r_uns  <= req_unsigned;
          r_cnt  <= CNT_W'(READ_LAT);
        end
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
        if (w_done) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= w_fmt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench: driver pushes byte-array model results, negedge monitor checks responses.
module tb_dmem_lsu_ctrl;

  localparam int unsigned NB_COL    = 4;
  localparam int unsigned COL_WIDTH = 8;
  localparam int unsigned RAM_DEPTH = 1024;
  localparam int unsigned READ_LAT  = 3;
  localparam int unsigned DW        = NB_COL * COL_WIDTH;
  localparam int unsigned LW        = $clog2(NB_COL);
  localparam int unsigned AW        = $clog2(RAM_DEPTH) + LW;
  localparam int unsigned NBYTES    = RAM_DEPTH * NB_COL;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  dmem_lsu_ctrl #(
    .NB_COL   (NB_COL),
    .COL_WIDTH(COL_WIDTH),
    .RAM_DEPTH(RAM_DEPTH),
    .READ_LAT (READ_LAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int unsigned   due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_m [NBYTES];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned last_due = 0;
  bit          last_keep = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_err(input int unsigned a, input int unsigned sz);
    return (sz == 3) || (sz == 2 && (a % NB_COL) != 0) || (sz == 1 && (a % 2) != 0);
  endfunction

  function automatic int unsigned model_nbytes(input int unsigned sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : NB_COL;
  endfunction

  function automatic logic [DW-1:0] model_load(input int unsigned a, input int unsigned sz,
                                               input bit uns);
    int unsigned   n;
    logic [DW-1:0] v;
    n = model_nbytes(sz);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v |= DW'(mem_m[a+i]) << (8 * i);
    if (!uns && n < NB_COL && ((v >> (8 * n - 1)) & DW'(1)) != '0)
      v |= ~((DW'(1) << (8 * n)) - DW'(1));
    return v;
  endfunction

  task automatic model_store(input int unsigned a, input int unsigned sz, input logic [DW-1:0] wd);
    int unsigned n;
    n = model_nbytes(sz);
    for (int unsigned i = 0; i < n; i++) mem_m[a+i] = 8'(wd >> (8 * i));
  endtask

  // Addresses confined to 16 prefilled words: 8 at the bottom, 8 at the top of memory.
  function automatic int unsigned region_word(input int unsigned k);
    return (k < 8) ? k : RAM_DEPTH - 16 + k;
  endfunction

  task automatic issue(input bit we, input int unsigned a, input int unsigned sz, input bit uns,
                       input logic [DW-1:0] wd, input bit keep);
    int unsigned waited;
    exp_t        e;
    waited       = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = AW'(a);
    req_size     = 2'(sz);
    req_unsigned = uns;
    req_wdata    = wd;
    @(negedge CLK);
    while (!req_ready && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    chk("accept_ready", req_ready, 1'b1);
    if (!req_ready) begin
      req_valid = 1'b0;
      last_keep = 1'b0;
      @(posedge CLK); #1;
      return;
    end
    if (last_keep) chk("b2b_accept_cycle", cyc, last_due);
    e.err   = model_err(a, sz);
    e.rdata = '0;
    if (!e.err && !we) e.rdata = model_load(a, sz, uns);
    if (!e.err && we) model_store(a, sz, wd);
    e.due = cyc + 1 + ((!e.err && !we) ? READ_LAT : 0);
    sb.push_back(e);
    last_due  = e.due;
    last_keep = keep;
    @(posedge CLK); #1;
    if (!keep) begin
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_addr     = AW'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = DW'($urandom);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        chk("rsp_missing", rsp_valid, 1'b1);
        sb.delete(0);
      end
    end
  end

  initial begin
    int unsigned k;
    int unsigned r;
    int unsigned sz;
    int unsigned a;
    int unsigned waited;

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", req_ready, 1'b1);
    @(posedge CLK); #1;

    for (int unsigned i = 0; i < 16; i++)
      issue(1'b1, region_word(i) * NB_COL, 2, 1'b0, DW'($urandom), 1'b0);

    issue(1'b1, 'h10, 2, 1'b0, 32'hA1B2C3D4, 1'b0);
    issue(1'b0, 'h10, 2, 1'b0, '0, 1'b0);
    issue(1'b1, 'h11, 0, 1'b0, {DW'($urandom) & 32'hFFFFFF00} | 32'h7F, 1'b0);
    issue(1'b0, 'h10, 2, 1'b1, '0, 1'b0);
    issue(1'b0, 'h13, 0, 1'b0, '0, 1'b0);
    issue(1'b0, 'h13, 0, 1'b1, '0, 1'b0);

    issue(1'b1, 'h22, 1, 1'b0, 32'h5A5A8001, 1'b0);
    issue(1'b0, 'h22, 1, 1'b0, '0, 1'b0);
    issue(1'b0, 'h22, 1, 1'b1, '0, 1'b0);
    issue(1'b0, 'h20, 1, 1'b1, '0, 1'b0);

    issue(1'b0, 'h12, 2, 1'b0, '0, 1'b0);
    issue(1'b1, 'h21, 1, 1'b0, 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 'h20, 3, 1'b0, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 'h20, 2, 1'b0, '0, 1'b0);

    // Reset while the load sits in RD_WAIT: its response must never appear.
    issue(1'b0, 'h10, 2, 1'b0, '0, 1'b0);
    RST = 1'b1;
    sb.delete();
    repeat (2) begin
      @(negedge CLK);
      chk("rst_mid_req_ready", req_ready, 1'b0);
      chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_mid_reset", req_ready, 1'b1);
    @(posedge CLK); #1;
    repeat (READ_LAT + 2) @(posedge CLK);
    #1;
    issue(1'b0, 'h10, 2, 1'b0, '0, 1'b0);
    issue(1'b0, 'h22, 1, 1'b0, '0, 1'b0);

    for (int unsigned i = 0; i < 8; i++) begin
      a = region_word(i / 2 + 1) * NB_COL;
      issue((i % 2) == 0, a, 2, 1'b0, DW'($urandom), i != 7);
    end

    for (int unsigned i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 15);
      a  = region_word(k) * NB_COL + $urandom_range(0, NB_COL - 1);
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      issue(1'($urandom), a, sz, 1'($urandom), DW'($urandom), 1'($urandom));
    end
    req_valid = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    chk("drain_pending", sb.size(), 0);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
